// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, single-outstanding imem requests, tagged instruction FIFO,
// branch redirect with draining of the in-flight wrong-path response.
module fetch_stage #(
  parameter logic [0:63] RESET_PC   = 64'h0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [0:63] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [0:31] imem_rdata,
  input  logic        branch_taken,
  input  logic [0:63] branch_target,
  input  logic        stall,
  output logic [0:31] instruction,
  output logic [0:63] instr_pc,
  output logic        instr_valid
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [0:63]   pc_q, pc_d;
  logic [0:63]   req_pc_q, req_pc_d;
  logic          outstanding_q, outstanding_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [0:31] fifo_word_q [FIFO_DEPTH];
  logic [0:63] fifo_pc_q   [FIFO_DEPTH];

  logic [CW:0] occupancy;
  logic        fire;
  logic        push;
  logic        pop;

  // In-flight request counts against capacity so the FIFO can never overflow.
  assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, outstanding_q};

  assign imem_req  = !rst && (state_q == S_FETCH) && !branch_taken &&
                     (occupancy < {1'b0, DEPTH_C});
  assign imem_addr = pc_q;
  assign fire      = imem_req && imem_ready;

  assign instr_valid = (count_q != '0);
  assign instruction = instr_valid ? fifo_word_q[rd_ptr_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[rd_ptr_q]   : '0;

  assign push = (state_q == S_WAIT) && imem_rvalid && !branch_taken;
  assign pop  = instr_valid && !stall && !branch_taken;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    req_pc_d      = req_pc_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;

    if (branch_taken) begin
      pc_d     = branch_target & ~64'h3;
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      // A still-pending response must be swallowed before fetching again.
      if (outstanding_q && !imem_rvalid) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
      outstanding_d = outstanding_q && !imem_rvalid;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (fire) begin
            pc_d          = pc_q + 64'd4;
            req_pc_d      = pc_q;
            outstanding_d = 1'b1;
            state_d       = S_WAIT;
          end
        end
        S_WAIT, S_DRAIN: begin
          if (imem_rvalid) begin
            outstanding_d = 1'b0;
            state_d       = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      count_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_pc_q      <= req_pc_d;
      outstanding_q <= outstanding_d;
      count_q       <= count_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
    end
  end

  // NOTE: buffer storage is not reset; count_q alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_word_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory responder, scoreboard of expected {pc, word},
// and a monitor that checks every instruction decode consumes.
module tb_fetch_stage;

  localparam logic [0:63] RESET_PC = 64'h0;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [0:63] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [0:31] imem_rdata;
  logic        branch_taken;
  logic [0:63] branch_target;
  logic        stall;
  logic [0:31] instruction;
  logic [0:63] instr_pc;
  logic        instr_valid;

  fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .instruction  (instruction),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] acc_addr[$];
  int          acc_cyc[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  logic [63:0] mem_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mword(input logic [63:0] a);
    return 32'hC0DE_0000 | {16'h0, a[15:0]};
  endfunction

  task automatic push_exp(input logic [63:0] pc, input logic [31:0] word);
    exp_t e;
    e.pc   = pc;
    e.word = word;
    exp_q.push_back(e);
  endtask

  // Memory: accepts on imem_req&imem_ready, answers mem_lat cycles later.
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (rst) begin
        mem_cnt = 0;
      end else begin
        if (mem_cnt > 0) begin
          mem_cnt--;
          if (mem_cnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mword(mem_addr);
          end
        end
        if (imem_req && imem_ready) begin
          mem_addr = imem_addr;
          mem_cnt  = mem_lat;
          acc_addr.push_back(imem_addr);
          acc_cyc.push_back(cyc);
        end
      end
    end
  end

  // Monitor: every word decode consumes must be the next expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && !stall && !branch_taken) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop_pc", instr_pc, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("pop_pc", instr_pc, e.pc);
          check("pop_word", {32'h0, instruction}, {32'h0, e.word});
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input int n, input int budget);
    int b = 0;
    while (acc_addr.size() < n && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    check("accept_count", 64'(acc_addr.size()), 64'(n));
  endtask

  task automatic wait_empty(input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      step();
      b++;
    end
    repeat (4) step();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    check("fifo_empty", {63'h0, instr_valid}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; imem_ready = 1'b0; branch_taken = 1'b0; branch_target = '0; stall = 1'b0;

    // Reset state.
    step();
    #1;
    check("rst_req", {63'h0, imem_req}, 64'd0);
    check("rst_valid", {63'h0, instr_valid}, 64'd0);
    check("rst_instr", {32'h0, instruction}, 64'd0);
    check("rst_pc", instr_pc, 64'd0);
    check("rst_addr", imem_addr, RESET_PC);

    // Test 1: straight-line fetch, 1-cycle memory.
    rst = 1'b0; mem_lat = 1; imem_ready = 1'b1;
    push_exp(64'h0, 32'hC0DE_0000);
    push_exp(64'h4, 32'hC0DE_0004);
    push_exp(64'h8, 32'hC0DE_0008);
    wait_accepts(3, 40);
    step();
    imem_ready = 1'b0;
    wait_empty(40);
    check("t1_addr0", acc_addr[0], 64'h0);
    check("t1_addr1", acc_addr[1], 64'h4);
    check("t1_addr2", acc_addr[2], 64'h8);
    check("t1_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd2);

    // Test 2: stall fills the 2-entry buffer, then drains and fetch resumes at 8.
    rst = 1'b1; step(); rst = 1'b0;
    exp_q.delete(); acc_addr.delete(); acc_cyc.delete();
    stall = 1'b1; imem_ready = 1'b1;
    push_exp(64'h0, 32'hC0DE_0000);
    push_exp(64'h4, 32'hC0DE_0004);
    push_exp(64'h8, 32'hC0DE_0008);
    repeat (8) step();
    check("t2_accepts", 64'(acc_addr.size()), 64'd2);
    check("t2_req_full", {63'h0, imem_req}, 64'd0);
    check("t2_head_pc", instr_pc, 64'h0);
    check("t2_addr_held", imem_addr, 64'h8);
    stall = 1'b0;
    step();
    check("t2_next_head", instr_pc, 64'h4);
    wait_accepts(3, 20);
    step();
    imem_ready = 1'b0;
    wait_empty(40);
    check("t2_resume_addr", acc_addr[2], 64'h8);

    // Test 5: ready low for 5 cycles, request held stable.
    rst = 1'b1; step(); rst = 1'b0;
    exp_q.delete(); acc_addr.delete(); acc_cyc.delete();
    mem_lat = 2;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t5_req_held", {63'h0, imem_req}, 64'd1);
      check("t5_addr_held", imem_addr, 64'h0);
    end
    push_exp(64'h0, 32'hC0DE_0000);
    imem_ready = 1'b1;
    wait_accepts(1, 5);
    step();
    imem_ready = 1'b0;
    check("t5_pc_advanced", imem_addr, 64'h4);
    wait_empty(20);

    // Test 3: redirect to 0x10, then branch (misaligned 0x103) before rvalid.
    branch_taken = 1'b1; branch_target = 64'h10;
    #1;
    check("t3_req_forced0", {63'h0, imem_req}, 64'd0);
    step();
    branch_taken = 1'b0;
    check("t3_addr_10", imem_addr, 64'h10);
    mem_lat = 3; imem_ready = 1'b1;
    wait_accepts(2, 10);
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h103;
    step();
    branch_taken = 1'b0;
    #1;
    check("t3_drain_noreq", {63'h0, imem_req}, 64'd0);
    check("t3_aligned_addr", imem_addr, 64'h100);
    push_exp(64'h100, 32'hC0DE_0100);
    imem_ready = 1'b1;
    wait_accepts(3, 20);
    step();
    imem_ready = 1'b0;
    check("t3_target_req", acc_addr[2], 64'h100);
    wait_empty(20);

    // Test 4: branch coincides with rvalid while one word is buffered.
    stall = 1'b1; mem_lat = 1; imem_ready = 1'b1;
    wait_accepts(4, 20);
    wait_accepts(5, 20);
    step();
    imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'h200;
    #1;
    check("t4_rvalid_same", {63'h0, imem_rvalid}, 64'd0);
    check("t4_buffered", {63'h0, instr_valid}, 64'd1);
    @(negedge clk);
    check("t4_rvalid_coincide", {63'h0, imem_rvalid}, 64'd1);
    @(posedge clk);
    #1;
    branch_taken = 1'b0; stall = 1'b0;
    #1;
    check("t4_flushed", {63'h0, instr_valid}, 64'd0);
    check("t4_addr", imem_addr, 64'h200);
    check("t4_req", {63'h0, imem_req}, 64'd1);
    push_exp(64'h200, 32'hC0DE_0200);
    imem_ready = 1'b1;
    wait_accepts(6, 10);
    step();
    imem_ready = 1'b0;
    check("t4_target_req", acc_addr[5], 64'h200);
    wait_empty(20);

    // Test 6: reset while waiting with a word buffered.
    stall = 1'b1; mem_lat = 3; imem_ready = 1'b1;
    wait_accepts(8, 30);
    step();
    imem_ready = 1'b0;
    check("t6_pre_valid", {63'h0, instr_valid}, 64'd1);
    check("t6_pre_pc", instr_pc, 64'h204);
    check("t6_wait_noreq", {63'h0, imem_req}, 64'd0);
    rst = 1'b1; stall = 1'b0;
    step();
    check("t6_valid", {63'h0, instr_valid}, 64'd0);
    check("t6_instr", {32'h0, instruction}, 64'd0);
    check("t6_addr", imem_addr, RESET_PC);
    check("t6_req_in_rst", {63'h0, imem_req}, 64'd0);
    exp_q.delete(); acc_addr.delete(); acc_cyc.delete();
    rst = 1'b0;
    #1;
    check("t6_fetch_req", {63'h0, imem_req}, 64'd1);
    mem_lat = 2;
    push_exp(64'h0, 32'hC0DE_0000);
    imem_ready = 1'b1;
    wait_accepts(1, 5);
    step();
    imem_ready = 1'b0;
    wait_empty(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
